// File: rtl/pll_dyn_pkg.sv
// Shared types, constants and rPLL dynamic-port encoders for the PLL sequencers.
// Default presets assume a 27 MHz reference and keep VCO between 594 and 768 MHz.
package pll_dyn_pkg;

   typedef enum logic [1:0] {
      ST_RST_PLL,
      ST_WAIT_LOCK,
      ST_LOCKED,
      ST_ERROR
   } pll_state_e;

   localparam int unsigned ENTRY_W = 18;

   // IDSEL/FBDSEL carry the inverted (divider-1); ODSEL steps by 2 down from 64.
   function automatic logic [5:0] idsel_enc(input int unsigned div);
      return ~6'(div - 1);
   endfunction

   function automatic logic [5:0] fbdsel_enc(input int unsigned div);
      return ~6'(div - 1);
   endfunction

   function automatic logic [5:0] odsel_enc(input int unsigned div);
      return 6'(64 - div / 2);
   endfunction

   function automatic logic [ENTRY_W-1:0] make_entry(input int unsigned idiv,
                                                     input int unsigned fbdiv,
                                                     input int unsigned odiv);
      return {idsel_enc(idiv), fbdsel_enc(fbdiv), odsel_enc(odiv)};
   endfunction

   // Entry 0..3: 24, 48, 74.25, 12 MHz from 27 MHz.
   localparam logic [4*ENTRY_W-1:0] DEFAULT_TABLE = {
      make_entry(9, 4, 64),
      make_entry(4, 11, 8),
      make_entry(9, 16, 16),
      make_entry(9, 8, 32)
   };

endpackage

// File: rtl/pll_lock_filter.sv
// LOCK qualifier: 2-flop synchroniser followed by a saturating run-length counter.
// lock_ok needs LOCK_FILTER consecutive synchronised-high samples; lock_lost is the raw synchronised low.
module pll_lock_filter
   import pll_dyn_pkg::*;
#(
   parameter int unsigned LOCK_FILTER = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic lock_i,
   input  logic clear_i,
   output logic lock_ok,
   output logic lock_lost
);

   localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

   logic [1:0]    sync_q;
   logic [FW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], lock_i};
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != FW'(LOCK_FILTER)) begin
         cnt_d = cnt_q + FW'(1);
      end
   end

   assign lock_ok   = (cnt_q == FW'(LOCK_FILTER));
   assign lock_lost = ~sync_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Divider-preset sequencer for a Gowin rPLL with dynamic IDIV/FBDIV/ODIV selects.
// Drives RESET and the select pins, retries on lock timeout and gates the downstream reset.
module pll_dyn_ctrl
   import pll_dyn_pkg::*;
#(
   parameter int unsigned NUM_CFG      = 4,
   parameter logic [NUM_CFG*ENTRY_W-1:0] CFG_TABLE = (NUM_CFG*ENTRY_W)'(DEFAULT_TABLE),
   parameter int unsigned DEFAULT_CFG  = 0,
   parameter int unsigned RESET_CYCLES = 16,
   parameter int unsigned LOCK_FILTER  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned RETRY_MAX    = 3,
   localparam int unsigned CW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] cfg_sel,
   input  logic          cfg_req,
   input  logic          pll_lock_i,
   output logic          pll_reset_o,
   output logic [5:0]    pll_idsel_o,
   output logic [5:0]    pll_fbdsel_o,
   output logic [5:0]    pll_odsel_o,
   output logic          locked_o,
   output logic          rst_out_n,
   output logic          cfg_busy,
   output logic          cfg_done,
   output logic          cfg_err,
   output logic [CW-1:0] cur_cfg
);

   localparam int unsigned RCW = $clog2(RESET_CYCLES);
   localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RTW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   function automatic logic [ENTRY_W-1:0] table_entry(input logic [CW-1:0] idx);
      return ENTRY_W'(CFG_TABLE >> (32'(idx) * ENTRY_W));
   endfunction

   pll_state_e         state_q, state_d;
   logic [CW-1:0]      cur_cfg_q, cur_cfg_d;
   logic [ENTRY_W-1:0] sel_q, sel_d;
   logic               pll_reset_q, pll_reset_d;
   logic               locked_q, locked_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [RTW-1:0]     retry_q, retry_d;
   logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [TW-1:0]      to_cnt_q, to_cnt_d;
   logic               req_ok;
   logic               filt_clear, lock_ok, lock_lost;

   assign filt_clear = (state_q != ST_WAIT_LOCK);

   pll_lock_filter #(
      .LOCK_FILTER(LOCK_FILTER)
   ) u_lock_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .lock_i   (pll_lock_i),
      .clear_i  (filt_clear),
      .lock_ok  (lock_ok),
      .lock_lost(lock_lost)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST_PLL;
         cur_cfg_q   <= CW'(DEFAULT_CFG);
         sel_q       <= table_entry(CW'(DEFAULT_CFG));
         pll_reset_q <= 1'b1;
         locked_q    <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         retry_q     <= '0;
         rst_cnt_q   <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_cfg_q   <= cur_cfg_d;
         sel_q       <= sel_d;
         pll_reset_q <= pll_reset_d;
         locked_q    <= locked_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         retry_q     <= retry_d;
         rst_cnt_q   <= rst_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_cfg_d   = cur_cfg_q;
      sel_d       = sel_q;
      pll_reset_d = pll_reset_q;
      locked_d    = locked_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      retry_d     = retry_q;
      rst_cnt_d   = rst_cnt_q;
      to_cnt_d    = to_cnt_q;
      req_ok      = cfg_req && ((state_q == ST_LOCKED) || (state_q == ST_ERROR));

      unique case (state_q)
         ST_RST_PLL: begin
            if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
               state_d     = ST_WAIT_LOCK;
               pll_reset_d = 1'b0;
               rst_cnt_d   = '0;
               to_cnt_d    = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RCW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            // A lock qualified on the timeout cycle itself still wins.
            if (lock_ok) begin
               state_d  = ST_LOCKED;
               locked_d = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               retry_d  = '0;
            end else if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
               pll_reset_d = 1'b1;
               rst_cnt_d   = '0;
               if (retry_q < RTW'(RETRY_MAX)) begin
                  state_d = ST_RST_PLL;
                  retry_d = retry_q + RTW'(1);
               end else begin
                  state_d = ST_ERROR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         ST_LOCKED: begin
            if (lock_lost) begin
               state_d     = ST_RST_PLL;
               pll_reset_d = 1'b1;
               locked_d    = 1'b0;
               busy_d      = 1'b1;
               retry_d     = '0;
               rst_cnt_d   = '0;
            end
         end
         ST_ERROR: begin
            pll_reset_d = 1'b1;
         end
      endcase

      // Placed last so an accepted request overrides a coincident lock loss.
      if (req_ok) begin
         if (32'(cfg_sel) < NUM_CFG) begin
            state_d     = ST_RST_PLL;
            cur_cfg_d   = cfg_sel;
            sel_d       = table_entry(cfg_sel);
            pll_reset_d = 1'b1;
            locked_d    = 1'b0;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            retry_d     = '0;
            rst_cnt_d   = '0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign pll_reset_o  = pll_reset_q;
   assign pll_idsel_o  = sel_q[17:12];
   assign pll_fbdsel_o = sel_q[11:6];
   assign pll_odsel_o  = sel_q[5:0];
   assign locked_o     = locked_q;
   assign rst_out_n    = locked_q;
   assign cfg_busy     = busy_q;
   assign cfg_done     = done_q;
   assign cfg_err      = err_q;
   assign cur_cfg      = cur_cfg_q;

endmodule
